// File: rtl/mlow_job_scheduler.sv
// Shared MLow codec core scheduler: round-robin encode/decode grant, per-job config latch,
// start pulse, and supervision of completion, core error, abort and timeout.
module mlow_job_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CNT_W          = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             enc_req_i,
  output logic             enc_ack_o,
  input  logic             dec_req_i,
  output logic             dec_ack_o,
  input  logic [3:0]       bitrate_sel_i,
  input  logic [1:0]       bandwidth_sel_i,
  output logic             core_start_o,
  output logic             core_mode_o,
  output logic [15:0]      core_bitrate_o,
  output logic [1:0]       core_bandwidth_o,
  input  logic             core_done_i,
  input  logic             core_error_i,
  input  logic             abort_i,
  input  logic             err_clr_i,
  output logic             busy_o,
  output logic             timeout_o,
  output logic             error_o,
  output logic [CNT_W-1:0] enc_count_o,
  output logic [CNT_W-1:0] dec_count_o
);

  localparam int unsigned      TMR_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t           state;
  logic [TMR_W-1:0] timer;
  logic             last_enc;
  logic             grant_enc;

  function automatic logic [15:0] bitrate_map(input logic [3:0] sel);
    case (sel)
      4'd0:    return 16'd6000;
      4'd1:    return 16'd8000;
      4'd2:    return 16'd12000;
      4'd3:    return 16'd16000;
      4'd4:    return 16'd20000;
      4'd5:    return 16'd24000;
      4'd6:    return 16'd28000;
      default: return 16'd32000;
    endcase
  endfunction

  // Encode wins unless decode is also pending and encode was served last.
  assign grant_enc = enc_req_i & (~dec_req_i | ~last_enc);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state            <= IDLE;
      timer            <= '0;
      last_enc         <= 1'b0;
      enc_ack_o        <= 1'b0;
      dec_ack_o        <= 1'b0;
      core_start_o     <= 1'b0;
      core_mode_o      <= 1'b0;
      core_bitrate_o   <= 16'd16000;
      core_bandwidth_o <= 2'b01;
      busy_o           <= 1'b0;
      timeout_o        <= 1'b0;
      error_o          <= 1'b0;
      enc_count_o      <= '0;
      dec_count_o      <= '0;
    end else begin
      enc_ack_o    <= 1'b0;
      dec_ack_o    <= 1'b0;
      core_start_o <= 1'b0;
      timeout_o    <= 1'b0;
      // A fresh error below overrides this clear.
      if (err_clr_i) error_o <= 1'b0;

      case (state)
        IDLE: begin
          if (enc_req_i || dec_req_i) begin
            state            <= ISSUE;
            core_mode_o      <= grant_enc;
            core_bitrate_o   <= bitrate_map(bitrate_sel_i);
            core_bandwidth_o <= bandwidth_sel_i;
            core_start_o     <= 1'b1;
            enc_ack_o        <= grant_enc;
            dec_ack_o        <= ~grant_enc;
            busy_o           <= 1'b1;
          end
        end
        ISSUE: begin
          last_enc <= core_mode_o;
          timer    <= '0;
          if (abort_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else begin
            state  <= RUN;
          end
        end
        RUN: begin
          if (abort_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
          end else if (core_done_i) begin
            state  <= IDLE;
            busy_o <= 1'b0;
            if (core_error_i)     error_o     <= 1'b1;
            else if (core_mode_o) enc_count_o <= enc_count_o + CNT_W'(1);
            else                  dec_count_o <= dec_count_o + CNT_W'(1);
          end else if (timer == TMR_LAST) begin
            state     <= IDLE;
            busy_o    <= 1'b0;
            timeout_o <= 1'b1;
            error_o   <= 1'b1;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mlow_job_scheduler.sv
// Bench for mlow_job_scheduler: job-level reference model checked every cycle, directed
// scenarios with literal expectations, then randomized requesters/core/abort traffic.
module tb_mlow_job_scheduler;

  localparam int unsigned T  = 16;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          enc_req_i, dec_req_i, enc_ack_o, dec_ack_o;
  logic [3:0]    bitrate_sel_i = 4'd0;
  logic [1:0]    bandwidth_sel_i = 2'd0;
  logic          core_start_o, core_mode_o;
  logic [15:0]   core_bitrate_o;
  logic [1:0]    core_bandwidth_o;
  logic          core_done_i, core_error_i;
  logic          abort_i = 1'b0, err_clr_i = 1'b0;
  logic          busy_o, timeout_o, error_o;
  logic [CW-1:0] enc_count_o, dec_count_o;

  always #5 clk = ~clk;

  mlow_job_scheduler #(.TIMEOUT_CYCLES(T), .CNT_W(CW)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .enc_req_i(enc_req_i), .enc_ack_o(enc_ack_o),
    .dec_req_i(dec_req_i), .dec_ack_o(dec_ack_o),
    .bitrate_sel_i(bitrate_sel_i), .bandwidth_sel_i(bandwidth_sel_i),
    .core_start_o(core_start_o), .core_mode_o(core_mode_o),
    .core_bitrate_o(core_bitrate_o), .core_bandwidth_o(core_bandwidth_o),
    .core_done_i(core_done_i), .core_error_i(core_error_i),
    .abort_i(abort_i), .err_clr_i(err_clr_i),
    .busy_o(busy_o), .timeout_o(timeout_o), .error_o(error_o),
    .enc_count_o(enc_count_o), .dec_count_o(dec_count_o)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Stimulus knobs shared by the requester and core responder processes.
  int enc_jobs = 0, dec_jobs = 0;
  int core_delay = 0;
  bit core_err = 1'b0;
  bit spurious_en = 1'b0;

  // Requesters: hold req until ack, one job per raise.
  initial begin
    bit rs;
    enc_req_i = 1'b0;
    dec_req_i = 1'b0;
    forever begin
      @(posedge clk);
      rs = reset_i;
      #1;
      if (rs) begin
        enc_req_i = 1'b0;
        dec_req_i = 1'b0;
      end else begin
        if (enc_ack_o) enc_req_i = 1'b0;
        else if (!enc_req_i && enc_jobs > 0) begin enc_req_i = 1'b1; enc_jobs--; end
        if (dec_ack_o) dec_req_i = 1'b0;
        else if (!dec_req_i && dec_jobs > 0) begin dec_req_i = 1'b1; dec_jobs--; end
      end
    end
  end

  // Core responder: done pulse core_delay cycles after start (0 = never), plus optional noise.
  initial begin
    bit rs;
    int cnt;
    cnt = 0;
    core_done_i  = 1'b0;
    core_error_i = 1'b0;
    forever begin
      @(posedge clk);
      rs = reset_i;
      #1;
      core_done_i  = 1'b0;
      core_error_i = 1'b0;
      if (rs) cnt = 0;
      else if (core_start_o) cnt = core_delay;
      else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin core_done_i = 1'b1; core_error_i = core_err; end
      end else if (spurious_en && $urandom_range(0, 15) == 0) begin
        core_done_i  = 1'b1;
        core_error_i = 1'($urandom_range(0, 1));
      end
    end
  end

  // Job-level reference model: a job is either absent or has an age (0 = issue cycle,
  // k = k-th cycle the core has been running it).
  bit          m_valid = 1'b0;
  bit          m_in_job, m_last_enc, m_mode, m_start, m_ack_e, m_ack_d, m_busy, m_to, m_err;
  int          m_age, m_bitrate, m_enc, m_dec;
  logic [1:0]  m_bw;

  function automatic int rate_of(input logic [3:0] sel);
    int s;
    s = (int'(sel) > 7) ? 7 : int'(sel);
    if (s == 0) return 6000;
    if (s == 1) return 8000;
    return 4000 * (s + 1);
  endfunction

  initial begin
    bit win, fin, set_err;
    forever begin
      @(posedge clk);
      if (reset_i) begin
        m_valid = 1'b1; m_in_job = 1'b0; m_age = 0; m_last_enc = 1'b0;
        m_mode = 1'b0; m_bitrate = 16000; m_bw = 2'b01;
        m_start = 1'b0; m_ack_e = 1'b0; m_ack_d = 1'b0; m_busy = 1'b0;
        m_to = 1'b0; m_err = 1'b0; m_enc = 0; m_dec = 0;
      end else if (m_valid) begin
        m_start = 1'b0; m_ack_e = 1'b0; m_ack_d = 1'b0; m_to = 1'b0;
        fin = 1'b0; set_err = 1'b0;
        if (!m_in_job) begin
          if (enc_req_i || dec_req_i) begin
            win = enc_req_i && (!dec_req_i || !m_last_enc);
            m_in_job = 1'b1; m_age = 0; m_mode = win; m_last_enc = win;
            m_bitrate = rate_of(bitrate_sel_i); m_bw = bandwidth_sel_i;
            m_start = 1'b1; m_ack_e = win; m_ack_d = !win;
          end
        end else if (m_age == 0) begin
          if (abort_i) fin = 1'b1; else m_age = 1;
        end else begin
          if (abort_i) fin = 1'b1;
          else if (core_done_i) begin
            fin = 1'b1;
            if (core_error_i) set_err = 1'b1;
            else if (m_mode) m_enc = (m_enc + 1) % (1 << CW);
            else m_dec = (m_dec + 1) % (1 << CW);
          end else if (m_age == int'(T)) begin
            fin = 1'b1; m_to = 1'b1; set_err = 1'b1;
          end else m_age++;
        end
        if (fin) m_in_job = 1'b0;
        if (set_err) m_err = 1'b1;
        else if (err_clr_i) m_err = 1'b0;
        m_busy = m_in_job;
      end
    end
  end

  // Every-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        chk("enc_ack",   32'(enc_ack_o),        32'(m_ack_e));
        chk("dec_ack",   32'(dec_ack_o),        32'(m_ack_d));
        chk("start",     32'(core_start_o),     32'(m_start));
        chk("mode",      32'(core_mode_o),      32'(m_mode));
        chk("bitrate",   32'(core_bitrate_o),   32'(m_bitrate));
        chk("bandwidth", 32'(core_bandwidth_o), 32'(m_bw));
        chk("busy",      32'(busy_o),           32'(m_busy));
        chk("timeout",   32'(timeout_o),        32'(m_to));
        chk("error",     32'(error_o),          32'(m_err));
        chk("enc_count", 32'(enc_count_o),      32'(m_enc));
        chk("dec_count", 32'(dec_count_o),      32'(m_dec));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    enc_jobs = 0; dec_jobs = 0; abort_i = 1'b0; err_clr_i = 1'b0;
    core_delay = 0; core_err = 1'b0; spurious_en = 1'b0;
    reset_i = 1'b1;
    tick();
    tick();
    reset_i = 1'b0;
  endtask

  task automatic wait_start(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (core_start_o) ok = 1'b1;
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  initial begin
    int t_req, t_s, bsum, tsum, ngrant;
    logic [3:0] order;

    // Reset values and single encode job latency/config latch.
    do_reset();
    @(negedge clk);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_bitrate", 32'(core_bitrate_o), 32'd16000);
    chk("rst_bw", 32'(core_bandwidth_o), 32'd1);
    chk("rst_enc_count", 32'(enc_count_o), 32'd0);
    tick();
    bitrate_sel_i = 4'd3; bandwidth_sel_i = 2'd2; core_delay = 3; enc_jobs = 1;
    t_req = -1; t_s = -1;
    for (int i = 0; i < 20 && t_s < 0; i++) begin
      @(negedge clk);
      if (enc_req_i && t_req < 0) t_req = i;
      if (core_start_o) t_s = i;
    end
    chk("t1_latency", 32'(t_s - t_req), 32'd1);
    chk("t1_ack", 32'(enc_ack_o), 32'd1);
    chk("t1_mode", 32'(core_mode_o), 32'd1);
    chk("t1_bitrate", 32'(core_bitrate_o), 32'd16000);
    chk("t1_bw", 32'(core_bandwidth_o), 32'd2);
    chk("t1_busy", 32'(busy_o), 32'd1);
    repeat (8) @(negedge clk);
    chk("t1_enc_count", 32'(enc_count_o), 32'd1);

    // Contended requests alternate E,D,E,D.
    do_reset();
    core_delay = 10; enc_jobs = 2; dec_jobs = 2;
    order = 4'd0; ngrant = 0;
    for (int i = 0; i < 200 && ngrant < 4; i++) begin
      @(negedge clk);
      if (enc_ack_o) begin order = {order[2:0], 1'b1}; ngrant++; end
      if (dec_ack_o) begin order = {order[2:0], 1'b0}; ngrant++; end
    end
    chk("t2_order", 32'(order), 32'b1010);
    repeat (15) @(negedge clk);
    chk("t2_enc_count", 32'(enc_count_o), 32'd2);
    chk("t2_dec_count", 32'(dec_count_o), 32'd2);

    // Timeout: issue + T run cycles busy, one timeout pulse.
    do_reset();
    core_delay = 0; enc_jobs = 1;
    wait_start("t3_start");
    bsum = 0; tsum = 0;
    for (int i = 0; i < 40; i++) begin
      bsum += int'(busy_o); tsum += int'(timeout_o);
      @(negedge clk);
    end
    chk("t3_busy_cycles", 32'(bsum), 32'(T + 1));
    chk("t3_timeouts", 32'(tsum), 32'd1);
    chk("t3_error", 32'(error_o), 32'd1);
    chk("t3_enc_count", 32'(enc_count_o), 32'd0);

    // Decode job failing in the core, then error clear.
    do_reset();
    core_delay = 5; core_err = 1'b1; dec_jobs = 1;
    wait_start("t4_start");
    chk("t4_mode", 32'(core_mode_o), 32'd0);
    repeat (10) @(negedge clk);
    chk("t4_error", 32'(error_o), 32'd1);
    chk("t4_dec_count", 32'(dec_count_o), 32'd0);
    tick();
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    @(negedge clk);
    chk("t4_error_clr", 32'(error_o), 32'd0);

    // Abort in the third run cycle; later done pulses ignored.
    do_reset();
    core_delay = 0; enc_jobs = 1;
    wait_start("t5_start");
    tick(); tick(); tick();
    abort_i = 1'b1;
    tick();
    abort_i = 1'b0;
    @(negedge clk);
    chk("t5_busy_after_abort", 32'(busy_o), 32'd0);
    spurious_en = 1'b1;
    repeat (30) tick();
    spurious_en = 1'b0;
    @(negedge clk);
    chk("t5_enc_count", 32'(enc_count_o), 32'd0);
    chk("t5_error", 32'(error_o), 32'd0);

    // Clamped bitrate; done on the timeout threshold cycle wins.
    do_reset();
    bitrate_sel_i = 4'd12; core_delay = int'(T); enc_jobs = 1;
    wait_start("t6_start");
    chk("t6_bitrate", 32'(core_bitrate_o), 32'd32000);
    tsum = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      tsum += int'(timeout_o);
    end
    chk("t6_timeouts", 32'(tsum), 32'd0);
    chk("t6_enc_count", 32'(enc_count_o), 32'd1);
    chk("t6_error", 32'(error_o), 32'd0);

    // Randomized traffic against the model.
    do_reset();
    spurious_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      tick();
      bitrate_sel_i   = 4'($urandom_range(0, 15));
      bandwidth_sel_i = 2'($urandom_range(0, 3));
      abort_i   = ($urandom_range(0, 39) == 0);
      err_clr_i = ($urandom_range(0, 19) == 0);
      core_err  = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 9))
        0:       core_delay = 0;
        1:       core_delay = int'(T);
        2:       core_delay = int'(T) + 1;
        default: core_delay = int'($urandom_range(1, 12));
      endcase
      if ($urandom_range(0, 5) == 0 && enc_jobs < 3) enc_jobs++;
      if ($urandom_range(0, 5) == 0 && dec_jobs < 3) dec_jobs++;
      reset_i = ($urandom_range(0, 799) == 0);
    end
    reset_i = 1'b0; abort_i = 1'b0; err_clr_i = 1'b0; spurious_en = 1'b0;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
